axi_lite_arb2: RTL and testbench
================================

Name: axi_lite_arb2

Overview:
- Round-robin arbiter. Shares one AXI-Lite slave port (the peripheral register block: CTRL 0x0, STATUS 0x4, DATA_IN 0x8, DATA_OUT 0xC) between two AXI-Lite masters, m0 and m1.
- Only one transaction, read or write, is outstanding on the slave at a time.
- Addresses, data and responses pass through unmodified.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mN_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  master N (N=0,1) write address channel.
- mN_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  master N write data channel.
- mN_bresp/bvalid/bready  out/out/in  2/1/1  master N write response channel.
- mN_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  master N read address channel.
- mN_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  master N read data channel.
- s_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  slave write address channel.
- s_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  slave write data channel.
- s_bresp/bvalid/bready  in/in/out  2/1/1  slave write response channel.
- s_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  slave read address channel.
- s_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  slave read data channel.

Behaviour:
- Registers:
  - FSM state, reset IDLE.
  - gnt (owner), reset 0.
  - is_wr.
  - rr_ptr (preferred master), reset 0.
  - aw_done, w_done, reset 0.
- Datapath:
  - Outputs are combinational muxes of registered state; no data is registered.
  - Non-owner master and all idle outputs drive 0: ready, bvalid, rvalid, resp, rdata.
  - In IDLE all slave valids and s_bready/s_rready are 0. This covers every output's reset value.
- Requests:
  - reqN_wr = mN_awvalid. reqN_rd = mN_arvalid. reqN = reqN_wr | reqN_rd.
  - A master asserting only wvalid does not request.
- IDLE:
  - If both request, rr_ptr wins; otherwise the sole requester wins.
  - Winner: write if reqN_wr, else read (write-first within a master).
  - Registers gnt/is_wr. Next state WR_ADDR or RD_ADDR. No slave valid in the decision cycle.
  - Latency: request seen in cycle N, slave valid in cycle N+1.
- WR_ADDR:
  - AW channel forwarded while !aw_done; W channel forwarded while !w_done.
  - aw_done/w_done set on the respective slave handshake, in either order or together.
  - When both are done (including same cycle), clear both flags and go to WR_RESP.
- WR_RESP:
  - B channel forwarded: s_bready = m_bready[gnt], m_bvalid[gnt] = s_bvalid, bresp passed.
  - On s_bvalid & bready: go to IDLE, rr_ptr <= ~gnt.
- RD_ADDR: AR forwarded; on handshake go to RD_RESP.
- RD_RESP:
  - R channel forwarded, rdata/rresp passed.
  - On s_rvalid & rready: go to IDLE, rr_ptr <= ~gnt.
- Master stalls:
  - Master valid deasserting mid-grant is an AXI violation. No checking; the arbiter waits.
- Boundary conditions:
  - Same master requests again in the IDLE cycle following completion: it still wins if the other master is idle.
  - Both masters requesting continuously get alternating grants.
  - Minimum cycles per write with zero-wait slave: 3 (IDLE, WR_ADDR, WR_RESP).
  - rst mid-transaction returns all registers to reset next edge. Outstanding slave response is lost; the slave shares rst.

Optional Feature:
- Macro AXI_ARB_STATS_EN.
- When defined:
  - Outputs gnt_cnt0, gnt_cnt1 (16 bits each) count completed transactions per master.
  - Each increments on the final B or R handshake and saturates at 0xFFFF.
  - Input stats_clr (1) zeroes both next cycle; clr wins over a simultaneous increment.
  - Counters reset to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single write, m0 awaddr 0x0, wdata 0x1, wstrb 0xF:
  - Slave sees 0x0/0x1/0xF one cycle after awvalid.
  - m0 bresp 2'b00.
  - m1 awready/wready stay 0 throughout.
- After reset, m0 write to 0x8 and m1 read of 0xC asserted same cycle:
  - m0 served first; m1 araddr 0xC on slave only after m0's B handshake.
  - rr_ptr=0 then 1.
- Both masters issue 4 back-to-back writes (m0 data 0xA0..A3, m1 0xB0..B3): slave W order A0,B0,A1,B1,A2,B2,A3,B3.
- m0 wvalid at cycle 1, awvalid at cycle 3, slave awready delayed 2 cycles:
  - W accepted first; no grant until cycle 3.
  - Single slave write; exactly one m0 bvalid.
- m1 reads 0x10, slave returns rresp 2'b10, rdata 0xDEADBEEF: m1 sees 2'b10/0xDEADBEEF; m0 rvalid stays 0.
- rst asserted in WR_RESP with s_bvalid low: next cycle all slave valids and master readies are 0, state IDLE, rr_ptr 0. With AXI_ARB_STATS_EN, counters 0.

Source files
------------

// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: round-robin arbiter sharing one AXI-Lite slave between two masters.
// Optional per-master completion counters when AXI_ARB_STATS_EN is defined.
module axi_lite_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef AXI_ARB_STATS_EN
    input  logic                    stats_clr,
    output logic [15:0]             gnt_cnt0,
    output logic [15:0]             gnt_cnt1,
`endif
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [1:0]              m0_bresp,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [1:0]              m1_bresp,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rvalid,
    output logic                    s_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP
    } state_t;

    state_t state;
    logic   gnt, is_wr, rr_ptr, aw_done, w_done;

    logic req0, req1, win, win_wr;
    assign req0   = m0_awvalid | m0_arvalid;
    assign req1   = m1_awvalid | m1_arvalid;
    assign win    = (req0 & req1) ? rr_ptr : req1;
    assign win_wr = win ? m1_awvalid : m0_awvalid;

    logic aw_fwd, w_fwd, b_fwd, ar_fwd, r_fwd;
    assign aw_fwd = (state == WR_ADDR) & ~aw_done;
    assign w_fwd  = (state == WR_ADDR) & ~w_done;
    assign b_fwd  = (state == WR_RESP);
    assign ar_fwd = (state == RD_ADDR);
    assign r_fwd  = (state == RD_RESP);

    // Slave side: owner's request, zeroed whenever the channel is closed
    assign s_awvalid = aw_fwd & (gnt ? m1_awvalid : m0_awvalid);
    assign s_awaddr  = !aw_fwd ? '0 : (gnt ? m1_awaddr : m0_awaddr);
    assign s_wvalid  = w_fwd & (gnt ? m1_wvalid : m0_wvalid);
    assign s_wdata   = !w_fwd ? '0 : (gnt ? m1_wdata : m0_wdata);
    assign s_wstrb   = !w_fwd ? '0 : (gnt ? m1_wstrb : m0_wstrb);
    assign s_bready  = b_fwd & (gnt ? m1_bready : m0_bready);
    assign s_arvalid = ar_fwd & (gnt ? m1_arvalid : m0_arvalid);
    assign s_araddr  = !ar_fwd ? '0 : (gnt ? m1_araddr : m0_araddr);
    assign s_rready  = r_fwd & (gnt ? m1_rready : m0_rready);

    logic own0, own1;
    assign own0 = ~gnt;
    assign own1 = gnt;

    assign m0_awready = aw_fwd & own0 & s_awready;
    assign m0_wready  = w_fwd & own0 & s_wready;
    assign m0_bvalid  = b_fwd & own0 & s_bvalid;
    assign m0_bresp   = (b_fwd & own0) ? s_bresp : 2'b00;
    assign m0_arready = ar_fwd & own0 & s_arready;
    assign m0_rvalid  = r_fwd & own0 & s_rvalid;
    assign m0_rdata   = (r_fwd & own0) ? s_rdata : '0;
    assign m0_rresp   = (r_fwd & own0) ? s_rresp : 2'b00;

    assign m1_awready = aw_fwd & own1 & s_awready;
    assign m1_wready  = w_fwd & own1 & s_wready;
    assign m1_bvalid  = b_fwd & own1 & s_bvalid;
    assign m1_bresp   = (b_fwd & own1) ? s_bresp : 2'b00;
    assign m1_arready = ar_fwd & own1 & s_arready;
    assign m1_rvalid  = r_fwd & own1 & s_rvalid;
    assign m1_rdata   = (r_fwd & own1) ? s_rdata : '0;
    assign m1_rresp   = (r_fwd & own1) ? s_rresp : 2'b00;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, done;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;
    assign b_hs  = s_bvalid & s_bready;
    assign r_hs  = s_rvalid & s_rready;
    assign done  = is_wr ? b_hs : r_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            is_wr   <= 1'b0;
            rr_ptr  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt   <= win;
                        is_wr <= win_wr;
                        state <= win_wr ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    // AW and W may complete in either order or together
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) state <= RD_RESP;
                end
                WR_RESP, RD_RESP: begin
                    if (done) begin
                        state  <= IDLE;
                        rr_ptr <= ~gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (done) begin
            if (!gnt && gnt_cnt0 != 16'hFFFF)
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt && gnt_cnt1 != 16'hFFFF)
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2: directed stimulus with a queue scoreboard for axi_lite_arb2.
// Drives at posedge+1, samples at negedge; slave model lives in the monitor loop.
module tb_axi_lite_arb2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][31:0] awaddr, wdata, araddr, rdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0][1:0]  bresp, rresp;
    logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0] arvalid, arready, rvalid, rready;

    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        s_awready = 1'b1;
    logic        s_wready  = 1'b1;
    logic        s_arready = 1'b1;
    logic        s_bvalid  = 1'b0;
    logic        s_rvalid  = 1'b0;
    logic [1:0]  s_bresp   = 2'b00;
    logic [1:0]  s_rresp   = 2'b00;
    logic [31:0] s_rdata   = 32'h0;

`ifdef AXI_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    axi_lite_arb2 dut (
        .clk(clk), .rst(rst),
`ifdef AXI_ARB_STATS_EN
        .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
        .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
        .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
        .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_rdata(rdata[0]), .m0_rresp(rresp[0]),
        .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
        .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
        .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
        .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_rdata(rdata[1]), .m1_rresp(rresp[1]),
        .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", nm);
    endtask

    // Expected traffic, pushed by the stimulus in the order it must appear
    logic [31:0] q_aw[$], q_ar[$];
    logic [35:0] q_w[$];
    logic [1:0]  q_b0[$], q_b1[$];
    logic [33:0] q_r0[$], q_r1[$];

    int  cyc = 0, b0_cyc = 0, b0_prev = 0, ar_cyc = 0, nb0 = 0;
    bit  m1_wr_seen = 0, m0_rv_seen = 0;
    int  aw_delay = 0, aw_cnt = 0;
    bit  b_hold = 0, sw_aw = 0, sw_w = 0;
    logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
    logic [31:0] sl_rdata = 32'h0;
    bit  rst_s, hs_aw, hs_w, hs_ar, hs_b, hs_r, aw_seen;

    // Monitor and slave model
    always begin
        @(negedge clk);
        cyc++;
        rst_s   = rst;
        aw_seen = s_awvalid;
        hs_aw   = s_awvalid && s_awready;
        hs_w    = s_wvalid && s_wready;
        hs_ar   = s_arvalid && s_arready;
        hs_b    = s_bvalid && s_bready;
        hs_r    = s_rvalid && s_rready;
        if (hs_aw) begin
            if (q_aw.size() == 0) bad("aw_unexpected");
            else chk("s_awaddr", s_awaddr, q_aw.pop_front());
        end
        if (hs_w) begin
            if (q_w.size() == 0) bad("w_unexpected");
            else chk("s_wdata_strb", {s_wdata, s_wstrb}, q_w.pop_front());
        end
        if (hs_ar) begin
            ar_cyc = cyc;
            if (q_ar.size() == 0) bad("ar_unexpected");
            else chk("s_araddr", s_araddr, q_ar.pop_front());
        end
        if (bvalid[0] && bready[0]) begin
            b0_prev = b0_cyc;
            b0_cyc  = cyc;
            nb0++;
            if (q_b0.size() == 0) bad("m0_b_unexpected");
            else chk("m0_bresp", bresp[0], q_b0.pop_front());
        end
        if (bvalid[1] && bready[1]) begin
            if (q_b1.size() == 0) bad("m1_b_unexpected");
            else chk("m1_bresp", bresp[1], q_b1.pop_front());
        end
        if (rvalid[0] && rready[0]) begin
            if (q_r0.size() == 0) bad("m0_r_unexpected");
            else chk("m0_rresp_rdata", {rresp[0], rdata[0]}, q_r0.pop_front());
        end
        if (rvalid[1] && rready[1]) begin
            if (q_r1.size() == 0) bad("m1_r_unexpected");
            else chk("m1_rresp_rdata", {rresp[1], rdata[1]}, q_r1.pop_front());
        end
        if (awready[1] || wready[1]) m1_wr_seen = 1;
        if (rvalid[0]) m0_rv_seen = 1;
        @(posedge clk);
        #1;
        if (rst_s) begin
            aw_cnt = 0; sw_aw = 0; sw_w = 0;
            s_bvalid = 1'b0; s_rvalid = 1'b0;
        end else begin
            if (hs_b) s_bvalid = 1'b0;
            if (hs_r) s_rvalid = 1'b0;
            if (hs_aw) sw_aw = 1;
            if (hs_w) sw_w = 1;
            if (aw_seen && !hs_aw) aw_cnt++;
            else aw_cnt = 0;
            if (sw_aw && sw_w && !b_hold && !s_bvalid) begin
                s_bvalid = 1'b1; s_bresp = sl_bresp;
                sw_aw = 0; sw_w = 0;
            end
            if (hs_ar) begin
                s_rvalid = 1'b1; s_rdata = sl_rdata; s_rresp = sl_rresp;
            end
        end
        s_awready = (aw_cnt >= aw_delay);
    end

    // All tasks start and end just after a rising edge
    task automatic master_wr(input int m, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input int w_lead);
        int n;
        bit aw_ok, w_ok, b_ok;
        wdata[m] = d; wstrb[m] = s; wvalid[m] = 1'b1; bready[m] = 1'b1;
        if (w_lead == 0) begin awaddr[m] = a; awvalid[m] = 1'b1; end
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 200) begin
            @(negedge clk);
            if (awvalid[m] && awready[m]) aw_ok = 1;
            if (wvalid[m] && wready[m]) w_ok = 1;
            @(posedge clk);
            #1;
            n++;
            if (aw_ok) awvalid[m] = 1'b0;
            if (w_ok) wvalid[m] = 1'b0;
            if (n == w_lead && !aw_ok) begin
                awaddr[m] = a; awvalid[m] = 1'b1;
            end
        end
        awvalid[m] = 1'b0; wvalid[m] = 1'b0;
        if (!(aw_ok && w_ok)) bad("wr_addr_timeout");
        b_ok = 0; n = 0;
        while (!b_ok && n < 200) begin
            @(negedge clk);
            if (bvalid[m] && bready[m]) b_ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!b_ok) bad("wr_resp_timeout");
    endtask

    task automatic master_rd(input int m, input logic [31:0] a);
        int n;
        bit ok;
        araddr[m] = a; arvalid[m] = 1'b1; rready[m] = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (arvalid[m] && arready[m]) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        arvalid[m] = 1'b0;
        if (!ok) bad("rd_addr_timeout");
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (rvalid[m] && rready[m]) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) bad("rd_resp_timeout");
    endtask

    task automatic clr_masters();
        awvalid = '0; wvalid = '0; arvalid = '0;
        bready = '0; rready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_masters();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain_chk(input string nm);
        chk(nm, q_aw.size() + q_w.size() + q_ar.size() + q_b0.size()
                + q_b1.size() + q_r0.size() + q_r1.size(), 0);
    endtask

    function automatic logic [14:0] outs();
        return {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                awready, wready, arready, bvalid, rvalid};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        clr_masters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 0);
`ifdef AXI_ARB_STATS_EN
        chk("reset_counters", {gnt_cnt0, gnt_cnt1}, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from m0, one-cycle grant latency
        m1_wr_seen = 0;
        q_aw.push_back(32'h0); q_w.push_back({32'h1, 4'hF}); q_b0.push_back(2'b00);
        fork
            master_wr(0, 32'h0, 32'h1, 4'hF, 0);
            begin
                @(negedge clk);
                chk("t1_decide_cycle", s_awvalid, 0);
                @(negedge clk);
                chk("t1_forward", {s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb},
                    {1'b1, 1'b1, 32'h0, 32'h1, 4'hF});
            end
        join
        chk("t1_m1_ready_idle", m1_wr_seen, 0);
        drain_chk("t1_drain");

        // Simultaneous m0 write and m1 read after reset
        do_reset();
        sl_rdata = 32'h1234_5678;
        q_aw.push_back(32'h8); q_w.push_back({32'h55, 4'hF}); q_b0.push_back(2'b00);
        q_ar.push_back(32'hC); q_r1.push_back({2'b00, 32'h1234_5678});
        fork
            master_wr(0, 32'h8, 32'h55, 4'hF, 0);
            master_rd(1, 32'hC);
        join
        chk("t2_read_after_b", ar_cyc > b0_cyc, 1);
        drain_chk("t2_drain");

        // Same master back-to-back alone: 3 cycles per write
        q_aw.push_back(32'h4); q_w.push_back({32'h21, 4'h3}); q_b0.push_back(2'b00);
        q_aw.push_back(32'h4); q_w.push_back({32'h22, 4'hC}); q_b0.push_back(2'b00);
        master_wr(0, 32'h4, 32'h21, 4'h3, 0);
        master_wr(0, 32'h4, 32'h22, 4'hC, 0);
        chk("t_same_master_gap", b0_cyc - b0_prev, 3);
        drain_chk("t_same_drain");

        // Both masters back-to-back: strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_aw.push_back(32'h8); q_w.push_back({32'hA0 + i, 4'hF});
            q_aw.push_back(32'h0); q_w.push_back({32'hB0 + i, 4'hF});
            q_b0.push_back(2'b00); q_b1.push_back(2'b00);
        end
        fork
            for (int i = 0; i < 4; i++) master_wr(0, 32'h8, 32'hA0 + i, 4'hF, 0);
            for (int j = 0; j < 4; j++) master_wr(1, 32'h0, 32'hB0 + j, 4'hF, 0);
        join
        drain_chk("t3_drain");
`ifdef AXI_ARB_STATS_EN
        chk("t3_counts", {gnt_cnt0, gnt_cnt1}, {16'd4, 16'd4});
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("t3_counts_clr", {gnt_cnt0, gnt_cnt1}, 0);
        @(posedge clk);
        #1;
`endif

        // W ahead of AW, slow slave awready
        aw_delay = 2;
        @(posedge clk);
        #1;
        nb0 = 0;
        q_aw.push_back(32'hC); q_w.push_back({32'h77, 4'h1}); q_b0.push_back(2'b00);
        fork
            master_wr(0, 32'hC, 32'h77, 4'h1, 2);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("t4_no_grant", {s_awvalid, s_wvalid, wready[0]}, 0);
                end
                @(negedge clk);
                chk("t4_w_first", {s_wvalid, s_awvalid, s_awready}, 3'b110);
            end
        join
        chk("t4_one_bvalid", nb0, 1);
        drain_chk("t4_drain");
        aw_delay = 0;
        @(posedge clk);
        #1;

        // Read with error response
        m0_rv_seen = 0;
        sl_rresp = 2'b10; sl_rdata = 32'hDEAD_BEEF;
        q_ar.push_back(32'h10); q_r1.push_back({2'b10, 32'hDEAD_BEEF});
        master_rd(1, 32'h10);
        chk("t5_m0_rvalid_idle", m0_rv_seen, 0);
        drain_chk("t5_drain");

        // Reset in WR_RESP while the slave holds off bvalid
        do_reset();
        q_aw.push_back(32'h4); q_w.push_back({32'h7, 4'hF}); q_b0.push_back(2'b00);
        master_wr(0, 32'h4, 32'h7, 4'hF, 0);
`ifdef AXI_ARB_STATS_EN
        chk("t6_count_before", {gnt_cnt0, gnt_cnt1}, {16'd1, 16'd0});
`endif
        b_hold = 1;
        q_aw.push_back(32'hC); q_w.push_back({32'h9, 4'hF});
        awaddr[1] = 32'hC; awvalid[1] = 1'b1;
        wdata[1] = 32'h9; wstrb[1] = 4'hF; wvalid[1] = 1'b1; bready[1] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_fwd", {s_awvalid, s_wvalid}, 2'b11);
        @(posedge clk);
        #1;
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in_wresp", {s_bready, s_bvalid}, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", outs(), 0);
`ifdef AXI_ARB_STATS_EN
        chk("t6_count_rst", {gnt_cnt0, gnt_cnt1}, 0);
`endif
        @(posedge clk);
        #1;
        b_hold = 0;
        q_aw.push_back(32'h0); q_w.push_back({32'h11, 4'hF}); q_b0.push_back(2'b00);
        q_aw.push_back(32'h4); q_w.push_back({32'h22, 4'hF}); q_b1.push_back(2'b00);
        fork
            master_wr(0, 32'h0, 32'h11, 4'hF, 0);
            master_wr(1, 32'h4, 32'h22, 4'hF, 0);
        join
        drain_chk("t6_rr_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
